// File: rtl/long_op_scheduler.sv
// Arbitrates int and fp long-latency requests onto one shared iterative divide/sqrt unit.
// Round-robin grant, one operation in flight, watchdog timeout and flush abort.
module long_op_scheduler #(
    parameter int MAX_CYCLES = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        int_req_valid,
    input  logic [4:0]  int_req_op,
    input  logic [31:0] int_req_a,
    input  logic [31:0] int_req_b,
    input  logic [4:0]  int_req_rd,
    output logic        int_req_ready,
    input  logic        fp_req_valid,
    input  logic [4:0]  fp_req_op,
    input  logic [31:0] fp_req_a,
    input  logic [31:0] fp_req_b,
    input  logic [4:0]  fp_req_rd,
    output logic        fp_req_ready,
    output logic        unit_start,
    output logic        unit_sel,
    output logic [4:0]  unit_op,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    input  logic        unit_done,
    input  logic [31:0] unit_result,
    output logic        int_resp_valid,
    output logic [31:0] int_resp_data,
    output logic [4:0]  int_resp_rd,
    output logic        fp_resp_valid,
    output logic [31:0] fp_resp_data,
    output logic [4:0]  fp_resp_rd,
    input  logic        flush,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [5:0] CNT_LAST = 6'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic        last_fp;
    logic        sel_q;
    logic [4:0]  op_q, rd_q;
    logic [31:0] a_q, b_q, res_q;
    logic [5:0]  cnt;
    logic        timeout_q;
    logic [31:0] int_data_q, fp_data_q;
    logic [4:0]  int_rd_q, fp_rd_q;

    logic int_win, fp_win, can_accept, accept;
    logic wait_done, wait_tmo, resp_fire;

    // last_fp = 1 means int wins the next tie; rst_n gates ready so it is 0 while held in reset
    assign int_win    = int_req_valid && (!fp_req_valid || last_fp);
    assign fp_win     = fp_req_valid && !int_win;
    assign can_accept = rst_n && (state == IDLE) && !flush;
    assign int_req_ready = can_accept && int_win;
    assign fp_req_ready  = can_accept && fp_win;
    assign accept     = int_req_ready || fp_req_ready;

    assign wait_done  = (state == WAIT) && !flush && unit_done;
    assign wait_tmo   = (state == WAIT) && !flush && !unit_done && (cnt == CNT_LAST);
    assign resp_fire  = (state == RESP) && !flush;

    assign unit_start = (state == ISSUE);
    assign unit_sel   = sel_q;
    assign unit_op    = op_q;
    assign unit_a     = a_q;
    assign unit_b     = b_q;
    assign busy       = (state != IDLE);
    assign timeout_err = timeout_q;

    // Response data shows the fresh result while valid, otherwise the last delivered value
    assign int_resp_valid = resp_fire && !sel_q;
    assign fp_resp_valid  = resp_fire && sel_q;
    assign int_resp_data  = int_resp_valid ? res_q : int_data_q;
    assign int_resp_rd    = int_resp_valid ? rd_q  : int_rd_q;
    assign fp_resp_data   = fp_resp_valid  ? res_q : fp_data_q;
    assign fp_resp_rd     = fp_resp_valid  ? rd_q  : fp_rd_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = ISSUE;
            ISSUE: state_nxt = flush ? IDLE : WAIT;
            WAIT: begin
                if (flush)                     state_nxt = IDLE;
                else if (wait_done || wait_tmo) state_nxt = RESP;
            end
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_fp    <= 1'b1;
            sel_q      <= 1'b0;
            op_q       <= '0;
            rd_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            cnt        <= '0;
            timeout_q  <= 1'b0;
            int_data_q <= '0;
            int_rd_q   <= '0;
            fp_data_q  <= '0;
            fp_rd_q    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_fp <= fp_req_ready;
                sel_q   <= fp_req_ready;
                op_q    <= fp_req_ready ? fp_req_op : int_req_op;
                a_q     <= fp_req_ready ? fp_req_a  : int_req_a;
                b_q     <= fp_req_ready ? fp_req_b  : int_req_b;
                rd_q    <= fp_req_ready ? fp_req_rd : int_req_rd;
            end
            if (state == ISSUE)     cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 6'd1;
            if (wait_done) res_q <= unit_result;
            if (wait_tmo) begin
                res_q     <= 32'hFFFF_FFFF;
                timeout_q <= 1'b1;
            end
            if (int_resp_valid) begin
                int_data_q <= res_q;
                int_rd_q   <= rd_q;
            end
            if (fp_resp_valid) begin
                fp_data_q <= res_q;
                fp_rd_q   <= rd_q;
            end
        end
    end

endmodule

// File: doc/long_op_scheduler.md
LONG_OP_SCHEDULER -- requirements
Module: long_op_scheduler

Interface
REQ-001 The block SHALL have parameter MAX_CYCLES, default 40, giving the watchdog limit in cycles for one shared-unit operation.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports int_req_valid (input, 1), int_req_op (input, 5; ALUOp codes 01101..10000 for div/divu/rem/remu), int_req_a (input, 32), int_req_b (input, 32), int_req_rd (input, 5) and int_req_ready (output, 1).
REQ-005 The block SHALL have ports fp_req_valid (input, 1), fp_req_op (input, 5; FPUOp 4 = fdiv, 5 = fsqrt), fp_req_a (input, 32), fp_req_b (input, 32), fp_req_rd (input, 5) and fp_req_ready (output, 1).
REQ-006 The block SHALL have ports unit_start (output, 1), unit_sel (output, 1; 0 = int, 1 = fp), unit_op (output, 5), unit_a (output, 32) and unit_b (output, 32), which drive the shared iterative divide/sqrt unit.
REQ-007 The block SHALL have ports unit_done (input, 1) and unit_result (input, 32) from the shared unit.
REQ-008 The block SHALL have ports int_resp_valid (output, 1), int_resp_data (output, 32), int_resp_rd (output, 5), fp_resp_valid (output, 1), fp_resp_data (output, 32) and fp_resp_rd (output, 5).
REQ-009 The block SHALL have port flush, input, 1 bit: pipeline flush that aborts the operation in flight.
REQ-010 The block SHALL have port busy (output, 1) and port timeout_err (output, 1; sticky).

Function
REQ-011 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-012 In IDLE, a request SHALL be accepted on a cycle where its valid and ready are both 1; ready SHALL be 1 only for the arbitration winner, and only in IDLE with flush = 0.
REQ-013 Arbitration SHALL be round-robin: when both requesters are valid, the one not granted last wins; after reset, int has priority.
REQ-014 On acceptance, the block SHALL latch op, a, b, rd and sel, record the winner as last-granted, and go to ISSUE.
REQ-015 ISSUE SHALL last exactly 1 cycle, with unit_start = 1 and unit_op/unit_a/unit_b/unit_sel driven from the latched values; the next state SHALL be WAIT.
REQ-016 unit_op/unit_a/unit_b/unit_sel SHALL hold their latched values through WAIT.
REQ-017 In WAIT, a 6-bit cycle counter SHALL start at 0 and increment every cycle.
REQ-018 unit_done = 1 in WAIT SHALL capture unit_result and go to RESP.
REQ-019 If the counter reaches MAX_CYCLES - 1 without unit_done, the block SHALL set timeout_err, capture result 32'hFFFFFFFF and go to RESP.
REQ-020 RESP SHALL last exactly 1 cycle, asserting the response valid of the latched requester with data and rd; the next state SHALL be IDLE.
REQ-021 Minimum latency from acceptance to response valid SHALL be 3 cycles (unit_done in the first WAIT cycle).
REQ-022 The block SHALL accept no new request in RESP; back-to-back operations SHALL therefore be spaced at least 4 cycles apart.
REQ-023 flush = 1 in ISSUE, WAIT or RESP SHALL return the FSM to IDLE next cycle and suppress any response valid that cycle; a unit_done arriving in the same cycle SHALL be discarded.
REQ-024 flush = 1 in IDLE SHALL block acceptance.
REQ-025 unit_done outside WAIT SHALL be ignored.
REQ-026 busy SHALL equal (state != IDLE).
REQ-027 Response valids SHALL be single-cycle pulses and never both 1.
REQ-028 Response data and rd SHALL hold their last value when valid = 0.

Reset
REQ-029 rst_n = 0 SHALL immediately force: state IDLE, all ready/valid/start outputs 0, busy 0, timeout_err 0, latched data/op/rd 0, counter 0, and last-granted set so int has priority.
REQ-030 Reset asserted mid-operation SHALL abandon the operation without emitting a response.
REQ-031 timeout_err SHALL clear only on reset.

Verification
REQ-032 Int only: int div a=100, b=7, unit_done 5 cycles after start with result 14 -> one int_resp_valid pulse with data 14, rd echoed; fp_resp_valid stays 0.
REQ-033 Simultaneous requests, both valid for 3 consecutive operations -> grants int, fp, int, with each response routed to the correct requester.
REQ-034 Flush in WAIT with unit_done in the same cycle -> no response valid, FSM in IDLE next cycle, and the next request accepted.
REQ-035 Timeout: MAX_CYCLES = 8, unit_done never asserted -> fp_resp_valid with data FFFFFFFF 10 cycles after acceptance, and timeout_err stays 1.
REQ-036 Reset during WAIT -> all outputs 0 asynchronously; after release, a stray unit_done produces no response.
